// File: rtl/data_mem_resp.sv
// data_mem_resp: handshaked word memory with programmable wait states.
// Accepts one read or byte-enabled write per request, then returns a one-cycle
// ready strobe carrying read data or an error flag.
module data_mem_resp #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned WAIT      = 2,
  parameter string       INIT_FILE = "memory.txt"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0]       mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  // Access-side view: live inputs when committing straight from IDLE, latched copy otherwise.
  logic              commit_c;
  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_be;
  logic              acc_err;
  logic [ADDR_W-1:0] acc_idx;
  logic              wr_en_c;

  // Next-state, request latching and response generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    commit_c  = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          cnt_d   = CNT_W'(WAIT);
          if (WAIT == 0) begin
            commit_c  = 1'b1;
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_be    = be;
            state_d   = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          commit_c = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:ADDR_W+2] != '0);
    acc_idx = acc_addr[ADDR_W+1:2];
    wr_en_c = commit_c && acc_we && !acc_err && !rst;

    if (commit_c) begin
      ready_d = 1'b1;
      err_d   = acc_err;
      if (acc_err) begin
        rdata_d = '0;
      end else if (!acc_we) begin
        rdata_d = mem[acc_idx];
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers; reset abandons any pending access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Byte-lane write at the commit edge; storage itself is never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en_c && acc_be[i]) begin
        mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: a WAIT=2 and a WAIT=0 instance, scoreboard-checked responses.
module tb_data_mem_resp;

  typedef struct packed {
    logic [31:0] rd;
    logic        er;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b;
  logic        we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, err_a, err_b, busy_a, busy_b;

  int checks   = 0;
  int failures = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  data_mem_resp #(.ADDR_W(16), .WAIT(2), .INIT_FILE("memory.txt")) u_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .rdata(rdata_a), .ready(ready_a), .err(err_a), .busy(busy_a)
  );

  data_mem_resp #(.ADDR_W(16), .WAIT(0), .INIT_FILE("memory.txt")) u_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .rdata(rdata_b), .ready(ready_b), .err(err_b), .busy(busy_b)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the WAIT=2 instance.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (!ready_a && err_a) begin
      failures++;
      $display("FAIL a_err_without_ready: got err=1 expected 0");
    end
    if (ready_a) begin
      checks++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected_ready: got ready=1 expected no response");
      end else begin
        e = q_a.pop_front();
        if (rdata_a !== e.rd) begin
          failures++;
          $display("FAIL a_rdata: got %h expected %h", rdata_a, e.rd);
        end
        checks++;
        if (err_a !== e.er) begin
          failures++;
          $display("FAIL a_err: got %b expected %b", err_a, e.er);
        end
      end
    end
  end

  // Monitor for the WAIT=0 instance.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (!ready_b && err_b) begin
      failures++;
      $display("FAIL b_err_without_ready: got err=1 expected 0");
    end
    if (ready_b) begin
      checks++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL b_unexpected_ready: got ready=1 expected no response");
      end else begin
        e = q_b.pop_front();
        if (rdata_b !== e.rd) begin
          failures++;
          $display("FAIL b_rdata: got %h expected %h", rdata_b, e.rd);
        end
        checks++;
        if (err_b !== e.er) begin
          failures++;
          $display("FAIL b_err: got %b expected %b", err_b, e.er);
        end
      end
    end
  end

  // One request: push expectation, drive, wait (bounded) for ready, check latency and busy.
  task automatic txn(input bit sel_b, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] e, input logic [31:0] exp_rd, input bit exp_er,
                     input int exp_lat, input bit mangle);
    int  k;
    bit  got;
    logic rdy, bsy;
    exp_t ex;
    ex.rd = exp_rd;
    ex.er = exp_er;
    if (sel_b) q_b.push_back(ex); else q_a.push_back(ex);
    @(negedge clk);
    we = w; addr = a; wdata = d; be = e;
    if (sel_b) req_b = 1'b1; else req_a = 1'b1;
    k   = 0;
    got = 1'b0;
    while (!got && k < 30) begin
      @(negedge clk);
      k++;
      if (mangle && k == 1) begin
        addr  = 32'h0000_0030;
        wdata = 32'h0;
      end
      rdy = sel_b ? ready_b : ready_a;
      bsy = sel_b ? busy_b : busy_a;
      check32("busy_while_pending", 32'(bsy), 32'd1);
      if (rdy) got = 1'b1;
    end
    req_a = 1'b0;
    req_b = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL ready_timeout: got no ready expected ready within 30 cycles");
    end else begin
      checks--;
      check32("latency", 32'(k), 32'(exp_lat));
    end
  endtask

  initial begin
    logic [4:0] pat;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    we = 1'b0; addr = '0; wdata = '0; be = '0;
    repeat (3) @(negedge clk);
    check32("reset_rdata_a", rdata_a, 32'h0);
    check32("reset_ctrl_a", {29'd0, ready_a, err_a, busy_a}, 32'h0);
    check32("reset_rdata_b", rdata_b, 32'h0);
    check32("reset_ctrl_b", {29'd0, ready_b, err_b, busy_b}, 32'h0);
    rst = 1'b0;

    // Image preload through the write port (rdata stays 0 across writes).
    txn(0, 1, 32'h0C, 32'hDEADBEEF, 4'hF, 32'h0, 0, 4, 0);
    txn(0, 1, 32'h10, 32'hAABBCCDD, 4'hF, 32'h0, 0, 4, 0);
    txn(0, 1, 32'h00, 32'h01234567, 4'hF, 32'h0, 0, 4, 0);
    txn(0, 1, 32'h20, 32'h55667788, 4'hF, 32'h0, 0, 4, 0);
    txn(0, 1, 32'h30, 32'h99999999, 4'hF, 32'h0, 0, 4, 0);

    // Basic read, partial write, read-back.
    txn(0, 0, 32'h0C, 32'h0, 4'h0, 32'hDEADBEEF, 0, 4, 0);
    txn(0, 1, 32'h10, 32'h11223344, 4'b0101, 32'hDEADBEEF, 0, 4, 0);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 32'hAA22CC44, 0, 4, 0);

    // Misaligned and out-of-range errors.
    txn(0, 0, 32'h0E, 32'h0, 4'h0, 32'h0, 1, 4, 0);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 32'hAA22CC44, 0, 4, 0);
    txn(0, 0, 32'h0004_0000, 32'h0, 4'h0, 32'h0, 1, 4, 0);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 32'hAA22CC44, 0, 4, 0);
    txn(0, 1, 32'h0004_0000, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 4, 0);
    txn(0, 0, 32'h00, 32'h0, 4'h0, 32'h01234567, 0, 4, 0);

    // Empty byte-enable write leaves the word alone.
    txn(0, 1, 32'h00, 32'h0, 4'b0000, 32'h01234567, 0, 4, 0);
    txn(0, 0, 32'h00, 32'h0, 4'h0, 32'h01234567, 0, 4, 0);

    // Inputs changed after acceptance must not affect the access.
    txn(0, 1, 32'h24, 32'h0F0E0D0C, 4'hF, 32'h01234567, 0, 4, 1);
    txn(0, 0, 32'h24, 32'h0, 4'h0, 32'h0F0E0D0C, 0, 4, 0);
    txn(0, 0, 32'h30, 32'h0, 4'h0, 32'h99999999, 0, 4, 0);

    // Reset one cycle after accepting a write: write discarded, outputs cleared.
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'hFFFFFFFF; be = 4'hF; req_a = 1'b1;
    @(negedge clk);
    check32("busy_after_accept", 32'(busy_a), 32'd1);
    rst = 1'b1;
    #1;
    check32("midop_reset_rdata", rdata_a, 32'h0);
    check32("midop_reset_ctrl", {29'd0, ready_a, err_a, busy_a}, 32'h0);
    req_a = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    txn(0, 0, 32'h20, 32'h0, 4'h0, 32'h55667788, 0, 4, 0);

    // WAIT=0 instance: preload, single-cycle latency.
    txn(1, 1, 32'h00, 32'hCAFEF00D, 4'hF, 32'h0, 0, 1, 0);
    txn(1, 1, 32'h04, 32'h0BADF00D, 4'hF, 32'h0, 0, 1, 0);
    txn(1, 0, 32'h00, 32'h0, 4'h0, 32'hCAFEF00D, 0, 1, 0);

    // Back-to-back reads with req held: one response every two cycles.
    q_b.push_back('{rd: 32'hCAFEF00D, er: 1'b0});
    q_b.push_back('{rd: 32'h0BADF00D, er: 1'b0});
    @(negedge clk);
    we = 1'b0; addr = 32'h00; be = 4'h0; req_b = 1'b1;
    pat = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      pat[k] = ready_b;
      if (k == 1) addr = 32'h04;
      if (k == 2) req_b = 1'b0;
    end
    check32("b2b_ready_pattern", 32'(pat), 32'h05);

    repeat (2) @(negedge clk);
    check32("queue_a_drained", 32'(q_a.size()), 32'd0);
    check32("queue_b_drained", 32'(q_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
